// File: rtl/mips_ucode_pkg.sv
// Shared encodings and defaults for the MIPS microcode next-address sequencer.
package mips_ucode_pkg;

  localparam int UPC_W_DEF      = 5;
  localparam int FETCH_ADDR_DEF = 0;
  localparam int FAULT_ADDR_DEF = 31;
  localparam int WAIT_LIMIT_DEF = 64;

  typedef enum logic [2:0] {
    AC_SEQ   = 3'b000,
    AC_FETCH = 3'b001,
    AC_DISP1 = 3'b010,
    AC_DISP2 = 3'b011,
    AC_JUMP  = 3'b100,
    AC_WAIT  = 3'b101,
    AC_CALL  = 3'b110,
    AC_RET   = 3'b111
  } addr_ctl_e;

  typedef enum logic {
    ST_RUN,
    ST_WAITING
  } seq_state_e;

endpackage

// File: rtl/mips_ucode_if.sv
// Control-store side bundle: micro-instruction fields, dispatch results, status out.
interface mips_ucode_if #(
  parameter int UPC_W = 5
);
  logic [2:0]       addr_ctl;
  logic [UPC_W-1:0] jump_addr;
  logic [UPC_W-1:0] disp1_addr;
  logic             disp1_valid;
  logic [UPC_W-1:0] disp2_addr;
  logic             disp2_valid;
  logic             mdu_busy;
  logic             hold;
  logic [UPC_W-1:0] upc;
  logic             in_wait;
  logic             dispatch_fault;
  logic             wait_timeout;

  modport master (
    output addr_ctl, jump_addr, disp1_addr, disp1_valid, disp2_addr, disp2_valid,
           mdu_busy, hold,
    input  upc, in_wait, dispatch_fault, wait_timeout
  );

  modport slave (
    input  addr_ctl, jump_addr, disp1_addr, disp1_valid, disp2_addr, disp2_valid,
           mdu_busy, hold,
    output upc, in_wait, dispatch_fault, wait_timeout
  );
endinterface

// File: rtl/mips_ucode_wait_timer.sv
// RUN/WAITING state machine for multiply stalls: busy counter, timeout detect, in_wait.
module mips_ucode_wait_timer
  import mips_ucode_pkg::*;
#(
  parameter int WAIT_LIMIT = WAIT_LIMIT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic hold,
  input  logic wait_req,
  input  logic mdu_busy,
  output logic active,
  output logic stall,
  output logic timeout,
  output logic in_wait
);

  localparam int CNT_W = (WAIT_LIMIT > 2) ? $clog2(WAIT_LIMIT) : 1;

  seq_state_e       state, state_n;
  logic [CNT_W-1:0] wait_cnt, cnt_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_RUN;
      wait_cnt <= '0;
      in_wait  <= 1'b0;
    end else if (!hold) begin
      state    <= state_n;
      wait_cnt <= cnt_n;
      in_wait  <= (state_n == ST_WAITING);
    end
  end

  // The entry cycle counts as the first busy cycle, so the timeout fires on
  // exactly the WAIT_LIMIT-th consecutive busy cycle.
  always_comb begin
    state_n = state;
    cnt_n   = wait_cnt;
    stall   = 1'b0;
    timeout = 1'b0;
    active  = (state == ST_WAITING);
    if (!hold) begin
      case (state)
        ST_RUN: begin
          if (wait_req && mdu_busy) begin
            state_n = ST_WAITING;
            cnt_n   = CNT_W'(1);
            stall   = 1'b1;
          end
        end
        ST_WAITING: begin
          if (!mdu_busy) begin
            state_n = ST_RUN;
            cnt_n   = '0;
          end else if (wait_cnt == CNT_W'(WAIT_LIMIT - 1)) begin
            state_n = ST_RUN;
            cnt_n   = '0;
            timeout = 1'b1;
          end else begin
            cnt_n = wait_cnt + 1'b1;
            stall = 1'b1;
          end
        end
        default: state_n = ST_RUN;
      endcase
    end
  end

endmodule

// File: rtl/mips_ucode_sequencer.sv
// Micro-PC next-address sequencer. Optional CALL/RET via a one-entry return
// register when UCODE_CALL_EN is defined; otherwise 110/111 fault to FETCH.
module mips_ucode_sequencer
  import mips_ucode_pkg::*;
#(
  parameter int UPC_W      = UPC_W_DEF,
  parameter int FETCH_ADDR = FETCH_ADDR_DEF,
  parameter int FAULT_ADDR = FAULT_ADDR_DEF,
  parameter int WAIT_LIMIT = WAIT_LIMIT_DEF
) (
  input logic        clk,
  input logic        rst_n,
  mips_ucode_if.slave bus
);

  localparam logic [UPC_W-1:0] FETCH_A = UPC_W'(FETCH_ADDR);
  localparam logic [UPC_W-1:0] FAULT_A = UPC_W'(FAULT_ADDR);

  logic [UPC_W-1:0] upc, upc_n, upc_inc;
  logic             dispatch_fault, df_n;
  logic             wait_timeout, wt_n;
  logic             wait_req, active, stall, timeout, in_wait;

  assign wait_req = (bus.addr_ctl == AC_WAIT);
  assign upc_inc  = upc + 1'b1;

  mips_ucode_wait_timer #(
    .WAIT_LIMIT (WAIT_LIMIT)
  ) u_wait_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .hold     (bus.hold),
    .wait_req (wait_req),
    .mdu_busy (bus.mdu_busy),
    .active   (active),
    .stall    (stall),
    .timeout  (timeout),
    .in_wait  (in_wait)
  );

`ifdef UCODE_CALL_EN
  logic [UPC_W-1:0] ret_reg, ret_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ret_reg <= FETCH_A;
    else        ret_reg <= ret_n;
  end
`endif

  always_comb begin
    upc_n = upc;
    df_n  = 1'b0;
    wt_n  = 1'b0;
`ifdef UCODE_CALL_EN
    ret_n = ret_reg;
`endif
    if (!bus.hold) begin
      // Once WAITING, addr_ctl is ignored and the timer alone steers upc.
      if (active || wait_req) begin
        if (timeout) begin
          upc_n = FAULT_A;
          wt_n  = 1'b1;
        end else if (!stall) begin
          upc_n = upc_inc;
        end
      end else begin
        case (bus.addr_ctl)
          AC_SEQ:   upc_n = upc_inc;
          AC_FETCH: upc_n = FETCH_A;
          AC_DISP1: begin
            upc_n = bus.disp1_valid ? bus.disp1_addr : FAULT_A;
            df_n  = !bus.disp1_valid;
          end
          AC_DISP2: begin
            upc_n = bus.disp2_valid ? bus.disp2_addr : FAULT_A;
            df_n  = !bus.disp2_valid;
          end
          AC_JUMP:  upc_n = bus.jump_addr;
`ifdef UCODE_CALL_EN
          AC_CALL: begin
            upc_n = bus.jump_addr;
            ret_n = upc_inc;
          end
          AC_RET:   upc_n = ret_reg;
          default:  upc_n = FETCH_A;
`else
          default: begin
            upc_n = FETCH_A;
            df_n  = 1'b1;
          end
`endif
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upc            <= FETCH_A;
      dispatch_fault <= 1'b0;
      wait_timeout   <= 1'b0;
    end else begin
      upc            <= upc_n;
      dispatch_fault <= df_n;
      wait_timeout   <= wt_n;
    end
  end

  assign bus.upc            = upc;
  assign bus.in_wait        = in_wait;
  assign bus.dispatch_fault = dispatch_fault;
  assign bus.wait_timeout   = wait_timeout;

endmodule

// File: tb/tb_mips_ucode_sequencer.sv
// Bench for mips_ucode_sequencer: vector table plus hand sequences for WAIT,
// timeout, hold, async reset and (with UCODE_CALL_EN) CALL/RET.
module tb_mips_ucode_sequencer;
  import mips_ucode_pkg::*;

  typedef struct {
    logic [2:0] ac;
    logic [4:0] ja;
    logic [4:0] d1;
    logic       d1v;
    logic [4:0] d2;
    logic       d2v;
    logic       busy;
    logic       hold;
    logic [4:0] upc;
    logic       iw;
    logic       df;
    logic       wt;
    string      name;
  } vec_t;

  typedef struct {
    logic [4:0] upc;
    logic       iw;
    logic       df;
    logic       wt;
    string      name;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];
  vec_t tbl[$];

  mips_ucode_if #(.UPC_W(5)) bus ();

  mips_ucode_sequencer #(
    .UPC_W(5), .FETCH_ADDR(0), .FAULT_ADDR(31), .WAIT_LIMIT(64)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t v(logic [2:0] ac, logic [4:0] ja, logic [4:0] d1, logic d1v,
                             logic [4:0] d2, logic d2v, logic busy, logic hold,
                             logic [4:0] upc, logic iw, logic df, logic wt, string name);
    vec_t r;
    r.ac = ac; r.ja = ja; r.d1 = d1; r.d1v = d1v; r.d2 = d2; r.d2v = d2v;
    r.busy = busy; r.hold = hold; r.upc = upc; r.iw = iw; r.df = df; r.wt = wt;
    r.name = name;
    return r;
  endfunction

  // Simple form for steps that do not exercise the dispatch tables.
  function automatic vec_t s(logic [2:0] ac, logic [4:0] ja, logic busy, logic hold,
                             logic [4:0] upc, logic iw, logic df, logic wt, string name);
    return v(ac, ja, 5'd0, 1'b1, 5'd0, 1'b1, busy, hold, upc, iw, df, wt, name);
  endfunction

  task automatic check(input exp_t e);
    n_cmp++;
    if (bus.upc !== e.upc || bus.in_wait !== e.iw ||
        bus.dispatch_fault !== e.df || bus.wait_timeout !== e.wt) begin
      n_bad++;
      $display("FAIL %s: got upc=%0d in_wait=%b df=%b wt=%b, want upc=%0d in_wait=%b df=%b wt=%b",
               e.name, bus.upc, bus.in_wait, bus.dispatch_fault, bus.wait_timeout,
               e.upc, e.iw, e.df, e.wt);
    end
  endtask

  task automatic apply(input vec_t x);
    exp_t e;
    bus.addr_ctl    = x.ac;
    bus.jump_addr   = x.ja;
    bus.disp1_addr  = x.d1;
    bus.disp1_valid = x.d1v;
    bus.disp2_addr  = x.d2;
    bus.disp2_valid = x.d2v;
    bus.mdu_busy    = x.busy;
    bus.hold        = x.hold;
    e.upc = x.upc; e.iw = x.iw; e.df = x.df; e.wt = x.wt; e.name = x.name;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard: got empty queue, want one entry");
    end else begin
      check(sb.pop_front());
    end
  endtask

  task automatic reset_check(input string name);
    exp_t e;
    e.upc = 5'd0; e.iw = 1'b0; e.df = 1'b0; e.wt = 1'b0; e.name = name;
    rst_n = 1'b0;
    #1;
    check(e);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    exp_t e0;
    logic [4:0] exp_upc;
    rst_n = 1'b0;
    bus.addr_ctl = AC_SEQ; bus.jump_addr = '0; bus.disp1_addr = '0; bus.disp1_valid = 1'b1;
    bus.disp2_addr = '0; bus.disp2_valid = 1'b1; bus.mdu_busy = 1'b0; bus.hold = 1'b0;
    #12;
    e0.upc = 5'd0; e0.iw = 1'b0; e0.df = 1'b0; e0.wt = 1'b0; e0.name = "reset";
    check(e0);
    rst_n = 1'b1;

    // SEQ counts through the whole store and wraps.
    exp_upc = 5'd0;
    for (int i = 0; i < 32; i++) begin
      exp_upc = exp_upc + 5'd1;
      apply(s(AC_SEQ, 5'd0, 1'b0, 1'b0, exp_upc, 1'b0, 1'b0, 1'b0, "seq_wrap"));
    end

    tbl.push_back(s(AC_JUMP, 5'd16, 1'b0, 1'b0, 5'd16, 1'b0, 1'b0, 1'b0, "jump16"));
    tbl.push_back(v(AC_DISP2, 5'd0, 5'd3, 1'b1, 5'd17, 1'b1, 1'b0, 1'b0, 5'd17, 1'b0, 1'b0, 1'b0, "disp2_17"));
    tbl.push_back(v(AC_DISP2, 5'd0, 5'd3, 1'b1, 5'd22, 1'b1, 1'b0, 1'b0, 5'd22, 1'b0, 1'b0, 1'b0, "disp2_22"));
    tbl.push_back(v(AC_DISP2, 5'd0, 5'd3, 1'b1, 5'd23, 1'b1, 1'b0, 1'b0, 5'd23, 1'b0, 1'b0, 1'b0, "disp2_23"));
    tbl.push_back(v(AC_DISP1, 5'd0, 5'd4, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 5'd31, 1'b0, 1'b1, 1'b0, "disp1_bad"));
    tbl.push_back(v(AC_DISP1, 5'd0, 5'd4, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 5'd31, 1'b0, 1'b1, 1'b0, "disp1_bad_b2b"));
    tbl.push_back(s(AC_SEQ, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, "seq_31_wrap"));
    tbl.push_back(v(AC_DISP1, 5'd0, 5'd9, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0, "disp1_9"));
    tbl.push_back(v(AC_DISP2, 5'd0, 5'd9, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd31, 1'b0, 1'b1, 1'b0, "disp2_bad"));
    tbl.push_back(s(AC_FETCH, 5'd7, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, "fetch"));
    tbl.push_back(s(AC_JUMP, 5'd5, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, "hold_jump"));
    tbl.push_back(v(AC_DISP1, 5'd0, 5'd4, 1'b0, 5'd9, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, "hold_no_pulse"));
    tbl.push_back(s(AC_WAIT, 5'd0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, "wait_not_busy"));
    tbl.push_back(s(AC_JUMP, 5'd18, 1'b0, 1'b0, 5'd18, 1'b0, 1'b0, 1'b0, "jump18"));
    foreach (tbl[i]) apply(tbl[i]);

    // Five busy cycles at upc 18; addr_ctl is ignored once waiting.
    apply(s(AC_WAIT, 5'd0, 1'b1, 1'b0, 5'd18, 1'b1, 1'b0, 1'b0, "wait5_enter"));
    for (int i = 0; i < 4; i++)
      apply(s(AC_JUMP, 5'd3, 1'b1, 1'b0, 5'd18, 1'b1, 1'b0, 1'b0, "wait5_hold"));
    apply(s(AC_JUMP, 5'd3, 1'b0, 1'b0, 5'd19, 1'b0, 1'b0, 1'b0, "wait5_exit"));

    // Stuck busy: 64th busy cycle redirects to the fault routine.
    for (int k = 1; k < 64; k++)
      apply(s(AC_WAIT, 5'd0, 1'b1, 1'b0, 5'd19, 1'b1, 1'b0, 1'b0, "timeout_busy"));
    apply(s(AC_WAIT, 5'd0, 1'b1, 1'b0, 5'd31, 1'b0, 1'b0, 1'b1, "timeout_fire"));
    apply(s(AC_SEQ, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, "timeout_pulse_end"));

    // Same, with a 10-cycle hold after 30 busy cycles.
    apply(s(AC_JUMP, 5'd20, 1'b0, 1'b0, 5'd20, 1'b0, 1'b0, 1'b0, "jump20"));
    for (int k = 1; k <= 30; k++)
      apply(s(AC_WAIT, 5'd0, 1'b1, 1'b0, 5'd20, 1'b1, 1'b0, 1'b0, "hto_busy_a"));
    for (int k = 0; k < 10; k++)
      apply(s(AC_WAIT, 5'd0, 1'b1, 1'b1, 5'd20, 1'b1, 1'b0, 1'b0, "hto_hold"));
    for (int k = 31; k < 64; k++)
      apply(s(AC_WAIT, 5'd0, 1'b1, 1'b0, 5'd20, 1'b1, 1'b0, 1'b0, "hto_busy_b"));
    apply(s(AC_WAIT, 5'd0, 1'b1, 1'b0, 5'd31, 1'b0, 1'b0, 1'b1, "hto_fire"));

    // Async reset with wait_cnt at 40.
    apply(s(AC_JUMP, 5'd7, 1'b0, 1'b0, 5'd7, 1'b0, 1'b0, 1'b0, "jump7"));
    for (int k = 1; k <= 40; k++)
      apply(s(AC_WAIT, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, "rst_wait_busy"));
    reset_check("reset_mid_wait");
    apply(s(AC_SEQ, 5'd0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, "post_reset_seq"));

    // Async reset kills a pending fault pulse.
    apply(v(AC_DISP1, 5'd0, 5'd4, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 5'd31, 1'b0, 1'b1, 1'b0, "disp1_bad_pre_rst"));
    reset_check("reset_kills_pulse");
    apply(s(AC_SEQ, 5'd0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, "post_reset_seq2"));

`ifdef UCODE_CALL_EN
    apply(s(AC_RET, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, "ret_reset_val"));
    apply(s(AC_JUMP, 5'd5, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, "jump5"));
    apply(s(AC_CALL, 5'd12, 1'b0, 1'b0, 5'd12, 1'b0, 1'b0, 1'b0, "call12"));
    apply(s(AC_SEQ, 5'd0, 1'b0, 1'b0, 5'd13, 1'b0, 1'b0, 1'b0, "call_body"));
    apply(s(AC_RET, 5'd0, 1'b0, 1'b0, 5'd6, 1'b0, 1'b0, 1'b0, "ret6"));
    apply(s(AC_CALL, 5'd20, 1'b0, 1'b0, 5'd20, 1'b0, 1'b0, 1'b0, "call20"));
    apply(s(AC_CALL, 5'd25, 1'b0, 1'b0, 5'd25, 1'b0, 1'b0, 1'b0, "call25_overwrite"));
    apply(s(AC_RET, 5'd0, 1'b0, 1'b0, 5'd21, 1'b0, 1'b0, 1'b0, "ret21"));
`else
    apply(s(AC_JUMP, 5'd5, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, "jump5"));
    apply(s(AC_CALL, 5'd12, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, "rsvd110"));
    apply(s(AC_JUMP, 5'd9, 1'b0, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0, "jump9"));
    apply(s(AC_RET, 5'd12, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, "rsvd111"));
    apply(s(AC_SEQ, 5'd0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, "rsvd_pulse_end"));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
